// File: rtl/shift_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_stack_pkg                                        |
// | Description : Op codes and slot-select encoding for the LIFO         |
// |               operand stack.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package shift_stack_pkg;

   // Three-bit stack operation code
   typedef logic [2:0] op_t;

   localparam op_t OP_NOP  = 3'b000;
   localparam op_t OP_PUSH = 3'b001;
   localparam op_t OP_POP  = 3'b010;
   localparam op_t OP_DUP  = 3'b011;
   localparam op_t OP_SWAP = 3'b100;
   localparam op_t OP_REPL = 3'b101;
   localparam op_t OP_P2P  = 3'b110;
   localparam op_t OP_CLR  = 3'b111;

   // Per-slot next-value source
   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,   // keep current value
      SEL_ABOVE = 3'd1,   // take entry i-1 (shift down, toward bottom)
      SEL_BELOW = 3'd2,   // take entry i+1 (shift up, toward top)
      SEL_DIN   = 3'd3,   // take external data
      SEL_ZERO  = 3'd4    // clear
   } sel_t;

endpackage : shift_stack_pkg
`default_nettype wire

// File: rtl/shift_stack_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stack_slot                                             |
// | Description : One WIDTH-bit stack entry with a five-way next-value   |
// |               select and asynchronous active-low reset.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stack_slot
   import shift_stack_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  sel_t             sel,
   input  logic [WIDTH-1:0] from_above,
   input  logic [WIDTH-1:0] from_below,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   // Entry register: load the selected source, or clear on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else begin
         case (sel)
            SEL_HOLD:  q <= q;
            SEL_ABOVE: q <= from_above;
            SEL_BELOW: q <= from_below;
            SEL_DIN:   q <= din;
            SEL_ZERO:  q <= '0;
            default:   q <= q;
         endcase
      end
   end

endmodule : stack_slot
`default_nettype wire

// File: rtl/shift_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_stack                                            |
// | Description : Parametrised LIFO operand stack built as a multi-entry |
// |               shift register. Exposes the top two entries to the ALU |
// |               and supports push/pop/dup/swap/replace/pop2push/clear. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module shift_stack
   import shift_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] nxt,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_TWO  = CW'(2);

   logic [WIDTH-1:0] w_slot_q [DEPTH];
   sel_t             w_sel    [DEPTH];
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_empty;
   logic             w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);

   // Entries at or beyond count are always zero, so the raw slots already
   // read as 0 when the stack is too shallow.
   assign top   = w_slot_q[0];
   assign nxt   = w_slot_q[1];
   assign count = r_count;
   assign empty = w_empty;
   assign full  = w_full;
   assign err   = r_err;

   // Entry storage: each slot sees its neighbours; the ends see zero
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [WIDTH-1:0] w_above;
      logic [WIDTH-1:0] w_below;

      if (i == 0) begin : g_first
         assign w_above = '0;
      end else begin : g_inner_above
         assign w_above = w_slot_q[i-1];
      end

      if (i == DEPTH - 1) begin : g_last
         assign w_below = '0;
      end else begin : g_inner_below
         assign w_below = w_slot_q[i+1];
      end

      stack_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .sel        (w_sel[i]),
         .from_above (w_above),
         .from_below (w_below),
         .din        (din),
         .q          (w_slot_q[i])
      );
   end

   // Op decode: per-slot selects, next count and error; illegal ops freeze
   // the entries and the count and only raise the sticky error.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_sel[i] = SEL_HOLD;
      end
      w_count_nxt = r_count;
      w_err_nxt   = r_err;

      if (en) begin
         case (op)
            OP_PUSH: begin
               if (w_full) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_sel[0] = SEL_DIN;
                  for (int i = 1; i < DEPTH; i++) begin
                     w_sel[i] = SEL_ABOVE;
                  end
                  w_count_nxt = r_count + C_ONE;
               end
            end
            OP_POP: begin
               if (w_empty) begin
                  w_err_nxt = 1'b1;
               end else begin
                  for (int i = 0; i < DEPTH; i++) begin
                     w_sel[i] = SEL_BELOW;
                  end
                  w_count_nxt = r_count - C_ONE;
               end
            end
            OP_DUP: begin
               if (w_full || w_empty) begin
                  w_err_nxt = 1'b1;
               end else begin
                  // Top keeps its value; everything else shifts down,
                  // so slot 1 receives a copy of the top.
                  for (int i = 1; i < DEPTH; i++) begin
                     w_sel[i] = SEL_ABOVE;
                  end
                  w_count_nxt = r_count + C_ONE;
               end
            end
            OP_SWAP: begin
               if (r_count < C_TWO) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_sel[0] = SEL_BELOW;
                  w_sel[1] = SEL_ABOVE;
               end
            end
            OP_REPL: begin
               if (w_empty) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_sel[0] = SEL_DIN;
               end
            end
            OP_P2P: begin
               if (r_count < C_TWO) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_sel[0] = SEL_DIN;
                  for (int i = 1; i < DEPTH; i++) begin
                     w_sel[i] = SEL_BELOW;
                  end
                  w_count_nxt = r_count - C_ONE;
               end
            end
            OP_CLR: begin
               for (int i = 0; i < DEPTH; i++) begin
                  w_sel[i] = SEL_ZERO;
               end
               w_count_nxt = '0;
               w_err_nxt   = 1'b0;
            end
            default: begin
               // NOP: hold everything
            end
         endcase
      end
   end

   // Occupancy count and sticky error register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule : shift_stack
`default_nettype wire

// File: tb/tb_shift_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shift_stack                                         |
// | Description : Self-checking bench for shift_stack: directed steps    |
// |               followed by random ops against a queue-based model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_shift_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             en;
   logic [2:0]       op;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] nxt;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: queue front is the top of stack
   logic [WIDTH-1:0] mq[$];
   logic             m_err;

   shift_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .op    (op),
      .din   (din),
      .top   (top),
      .nxt   (nxt),
      .count (count),
      .empty (empty),
      .full  (full),
      .err   (err)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic model_apply(input logic e, input logic [2:0] o, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] t;
      if (!e) return;
      case (o)
         3'b001: if (mq.size() == DEPTH) m_err = 1'b1; else mq.push_front(d);
         3'b010: if (mq.size() == 0) m_err = 1'b1; else void'(mq.pop_front());
         3'b011: if (mq.size() == 0 || mq.size() == DEPTH) m_err = 1'b1;
                 else mq.push_front(mq[0]);
         3'b100: if (mq.size() < 2) m_err = 1'b1;
                 else begin t = mq[0]; mq[0] = mq[1]; mq[1] = t; end
         3'b101: if (mq.size() == 0) m_err = 1'b1; else mq[0] = d;
         3'b110: if (mq.size() < 2) m_err = 1'b1;
                 else begin
                    void'(mq.pop_front());
                    void'(mq.pop_front());
                    mq.push_front(d);
                 end
         3'b111: begin mq.delete(); m_err = 1'b0; end
         default: ;
      endcase
   endtask

   task automatic check(input string tag);
      logic [WIDTH-1:0] e_top, e_nxt;
      logic [CW-1:0]    e_cnt;
      e_top = (mq.size() > 0) ? mq[0] : '0;
      e_nxt = (mq.size() > 1) ? mq[1] : '0;
      e_cnt = CW'(mq.size());
      n_assert++;
      assert (top === e_top) else begin
         n_fail++; $error("FAIL %s top: got %h expected %h", tag, top, e_top);
      end
      n_assert++;
      assert (nxt === e_nxt) else begin
         n_fail++; $error("FAIL %s nxt: got %h expected %h", tag, nxt, e_nxt);
      end
      n_assert++;
      assert (count === e_cnt) else begin
         n_fail++; $error("FAIL %s count: got %0d expected %0d", tag, count, e_cnt);
      end
      n_assert++;
      assert (empty === (mq.size() == 0)) else begin
         n_fail++; $error("FAIL %s empty: got %b expected %b", tag, empty, mq.size() == 0);
      end
      n_assert++;
      assert (full === (mq.size() == DEPTH)) else begin
         n_fail++; $error("FAIL %s full: got %b expected %b", tag, full, mq.size() == DEPTH);
      end
      n_assert++;
      assert (err === m_err) else begin
         n_fail++; $error("FAIL %s err: got %b expected %b", tag, err, m_err);
      end
   endtask

   // Spot check of top against a literal value from the test plan
   task automatic expect_top(input string tag, input logic [WIDTH-1:0] v);
      n_assert++;
      assert (top === v) else begin
         n_fail++; $error("FAIL %s top_lit: got %h expected %h", tag, top, v);
      end
   endtask

   // Drive one op, let it be sampled, then compare against the model
   task automatic step(input logic e, input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input string tag);
      en  = e;
      op  = o;
      din = d;
      @(posedge clk);
      #1;
      model_apply(e, o, d);
      check(tag);
   endtask

   initial begin
      logic [2:0]       r_op;
      logic [WIDTH-1:0] r_d;
      logic             r_en;

      rst = 1'b0; en = 1'b0; op = 3'b000; din = '0;
      mq.delete(); m_err = 1'b0;
      #2;
      check("reset");
      #10;
      rst = 1'b1;

      step(1'b1, 3'b001, 8'h11, "push11");
      step(1'b1, 3'b001, 8'h22, "push22");
      step(1'b1, 3'b001, 8'h33, "push33");
      expect_top("push33", 8'h33);
      step(1'b1, 3'b001, 8'h44, "push44_full");
      step(1'b1, 3'b001, 8'h55, "push55_overflow");
      expect_top("push55_overflow", 8'h44);
      step(1'b1, 3'b111, 8'h00, "clear1");
      step(1'b1, 3'b001, 8'h11, "refill11");
      step(1'b1, 3'b001, 8'h22, "refill22");
      step(1'b1, 3'b001, 8'h33, "refill33");
      step(1'b1, 3'b001, 8'h44, "refill44");
      step(1'b1, 3'b100, 8'h00, "swap");
      expect_top("swap", 8'h33);
      step(1'b1, 3'b110, 8'h77, "pop2push");
      expect_top("pop2push", 8'h77);
      step(1'b1, 3'b010, 8'h00, "pop_a");
      step(1'b1, 3'b010, 8'h00, "pop_b");
      step(1'b1, 3'b010, 8'h00, "pop_last");
      expect_top("pop_last", 8'h00);
      step(1'b1, 3'b010, 8'h00, "pop_underflow");
      step(1'b1, 3'b101, 8'h99, "repl_empty");
      step(1'b1, 3'b111, 8'h00, "clear2");
      step(1'b1, 3'b011, 8'h00, "dup_empty");
      step(1'b1, 3'b111, 8'h00, "clear3");
      step(1'b1, 3'b001, 8'h5A, "push5a");
      step(1'b1, 3'b100, 8'h00, "swap_one");
      step(1'b1, 3'b110, 8'h12, "p2p_one");
      step(1'b1, 3'b111, 8'h00, "clear4");
      step(1'b1, 3'b001, 8'h5A, "push5a_b");
      step(1'b1, 3'b011, 8'h00, "dup");
      step(1'b0, 3'b001, 8'hAA, "en_low1");
      step(1'b0, 3'b001, 8'hBB, "en_low2");
      step(1'b0, 3'b001, 8'hCC, "en_low3");
      step(1'b1, 3'b101, 8'h3C, "replace");
      step(1'b1, 3'b000, 8'hFF, "nop");
      step(1'b1, 3'b001, 8'h66, "push66");

      // Asynchronous reset between edges, with a PUSH pending on the inputs
      en = 1'b1; op = 3'b001; din = 8'hE1;
      #2;
      rst = 1'b0;
      #1;
      mq.delete(); m_err = 1'b0;
      check("async_rst");
      @(posedge clk);
      #1;
      check("rst_held");
      rst = 1'b1;
      step(1'b1, 3'b001, 8'hE1, "push_after_rst");
      expect_top("push_after_rst", 8'hE1);

      // Random phase: CLEAR de-weighted so the stack reaches full often
      for (int k = 0; k < 400; k++) begin
         r_en = ($urandom_range(0, 9) != 0);
         r_op = 3'($urandom_range(0, 7));
         if (r_op == 3'b111 && $urandom_range(0, 3) != 0) r_op = 3'b001;
         r_d  = WIDTH'($urandom);
         step(r_en, r_op, r_d, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_shift_stack
`default_nettype wire
